// File: rtl/uart_axi_pkg.sv
// rtl/uart_axi_pkg.sv - shared status codes, size enum and FSM state type for the UART-AXI bridge
package uart_axi_pkg;

   localparam logic [2:0] STATUS_OK         = 3'h0;
   localparam logic [2:0] STATUS_CMD_INV    = 3'h2;
   localparam logic [2:0] STATUS_ADDR_ALIGN = 3'h3;
   localparam logic [2:0] STATUS_BOUNDARY   = 3'h4;

   typedef enum logic [1:0] {
      SIZE_8  = 2'b00,
      SIZE_16 = 2'b01,
      SIZE_32 = 2'b10,
      SIZE_64 = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_ERR   = 2'b10
   } state_e;

   // Number of bytes moved by one beat of the given AXI SIZE encoding.
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/axi_strb_gen.sv
// rtl/axi_strb_gen.sv - combinational WSTRB generator from access size and address lane bits
module axi_strb_gen #(
   parameter int NB     = 4,
   parameter int LANE_W = 2
) (
   input  logic [1:0]        size,
   input  logic [LANE_W-1:0] addr_lo,
   output logic [NB-1:0]     strb
);

   logic [NB-1:0] mask;
   int            nbytes;

   // Contiguous mask of size-bytes lanes, shifted up to the lane the address starts on.
   always_comb begin
      nbytes = 1 << size;
      mask   = '0;
      for (int i = 0; i < NB; i++) begin
         if (i < nbytes) begin
            mask[i] = 1'b1;
         end
      end
      strb = mask << addr_lo;
   end

endmodule

// File: rtl/axi_beat_aligner.sv
// rtl/axi_beat_aligner.sv - burst request to registered AXI4-Lite beats; optional macro AXI_BEAT_ALIGNER_BOUNDARY_CHECK_EN
module axi_beat_aligner
   import uart_axi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [1:0]              req_size,
   input  logic [LEN_WIDTH-1:0]    req_len,
   input  logic                    req_inc,
   output logic                    beat_valid,
   input  logic                    beat_ready,
   output logic [ADDR_WIDTH-1:0]   beat_addr,
   output logic [DATA_WIDTH/8-1:0] beat_wstrb,
   output logic [LEN_WIDTH-1:0]    beat_idx,
   output logic                    beat_last,
   output logic                    err_valid,
   output logic [2:0]              err_status,
   output logic                    busy
);

   localparam int unsigned NB     = DATA_WIDTH / 8;
   localparam int          LANE_W = $clog2(NB);

   state_e                 state;
   size_e                  size_q;
   logic [LEN_WIDTH-1:0]   len_q;
   logic                   inc_q;

   logic [3:0]             req_bytes;
   logic                   cmd_inv;
   logic                   addr_misalign;
   logic                   page_cross;
   logic [2:0]             req_status;

   logic [ADDR_WIDTH-1:0]  adv_addr;
   logic [LEN_WIDTH-1:0]   adv_idx;
   logic [1:0]             strb_size;
   logic [LANE_W-1:0]      strb_lane;
   logic [NB-1:0]          strb_next;

   // Validate the offered request; the first failing check in priority order wins.
   always_comb begin
      req_bytes     = size_bytes(req_size);
      cmd_inv       = 32'(req_bytes) > NB;
      addr_misalign = (req_addr[3:0] & (req_bytes - 4'd1)) != 4'd0;
      if (cmd_inv) begin
         req_status = STATUS_CMD_INV;
      end else if (addr_misalign) begin
         req_status = STATUS_ADDR_ALIGN;
      end else if (page_cross) begin
         req_status = STATUS_BOUNDARY;
      end else begin
         req_status = STATUS_OK;
      end
   end

`ifdef AXI_BEAT_ALIGNER_BOUNDARY_CHECK_EN
   logic [ADDR_WIDTH-1:0] last_addr;

   // An incrementing burst is rejected when its final beat lands on a different 4 KB page.
   always_comb begin
      last_addr  = req_addr + (ADDR_WIDTH'(req_len) << req_size);
      page_cross = req_inc && (last_addr[ADDR_WIDTH-1:12] != req_addr[ADDR_WIDTH-1:12]);
   end
`else
   assign page_cross = 1'b0;
`endif

   // Next-beat address/index, and strobe source: the request itself in IDLE, the advanced beat otherwise.
   always_comb begin
      adv_addr  = inc_q ? beat_addr + ADDR_WIDTH'(size_bytes(size_q)) : beat_addr;
      adv_idx   = beat_idx + LEN_WIDTH'(1);
      strb_size = (state == ST_IDLE) ? req_size : size_q;
      strb_lane = (state == ST_IDLE) ? req_addr[LANE_W-1:0] : adv_addr[LANE_W-1:0];
   end

   axi_strb_gen #(
      .NB     (NB),
      .LANE_W (LANE_W)
   ) u_strb_gen (
      .size    (strb_size),
      .addr_lo (strb_lane),
      .strb    (strb_next)
   );

   // Request/issue/error FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         size_q     <= SIZE_8;
         len_q      <= '0;
         inc_q      <= 1'b0;
         req_ready  <= 1'b1;
         beat_valid <= 1'b0;
         beat_addr  <= '0;
         beat_wstrb <= '0;
         beat_idx   <= '0;
         beat_last  <= 1'b0;
         err_valid  <= 1'b0;
         err_status <= STATUS_OK;
         busy       <= 1'b0;
      end else begin
         err_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (req_status != STATUS_OK) begin
                     state      <= ST_ERR;
                     err_valid  <= 1'b1;
                     err_status <= req_status;
                  end else begin
                     state      <= ST_ISSUE;
                     size_q     <= size_e'(req_size);
                     len_q      <= req_len;
                     inc_q      <= req_inc;
                     beat_valid <= 1'b1;
                     beat_addr  <= req_addr;
                     beat_wstrb <= strb_next;
                     beat_idx   <= '0;
                     beat_last  <= (req_len == '0);
                  end
               end
            end
            ST_ISSUE: begin
               if (beat_ready) begin
                  if (beat_last) begin
                     state      <= ST_IDLE;
                     beat_valid <= 1'b0;
                     req_ready  <= 1'b1;
                     busy       <= 1'b0;
                  end else begin
                     beat_addr  <= adv_addr;
                     beat_wstrb <= strb_next;
                     beat_idx   <= adv_idx;
                     beat_last  <= (adv_idx == len_q);
                  end
               end
            end
            ST_ERR: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/axi_beat_aligner.md
# axi_beat_aligner

Parametrised, sequential successor to the combinational size/alignment checker. It accepts one burst request (start address, SIZE, beat count, increment/fixed mode) over a valid/ready handshake. It validates the request and then emits one registered AXI4-Lite beat per cycle, each with a byte address and WSTRB lanes, under downstream backpressure. It sits between the UART frame parser and the AXI4-Lite master and replaces per-beat address/strobe computation in the bridge.

## Interface
- DATA_WIDTH, 32: AXI data width; legal values are 32 or 64. NB = DATA_WIDTH/8.
- ADDR_WIDTH, 32: byte address width.
- LEN_WIDTH, 4: width of the beat count field; maximum burst is 2^LEN_WIDTH beats.
- clk  input  1  single clock; all logic is clocked on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_addr  input  ADDR_WIDTH  start byte address.
- req_size  input  2  access size: 00=8b, 01=16b, 10=32b, 11=64b.
- req_len  input  LEN_WIDTH  number of beats minus 1.
- req_inc  input  1  1 = incrementing address, 0 = fixed address.
- beat_valid  output  1  beat present.
- beat_ready  input  1  downstream accepts the beat.
- beat_addr  output  ADDR_WIDTH  byte address of the current beat.
- beat_wstrb  output  NB  byte lanes for the current beat.
- beat_idx  output  LEN_WIDTH  beat number, starting at 0.
- beat_last  output  1  high on the final beat.
- err_valid  output  1  one-cycle pulse when a request is rejected.
- err_status  output  3  0x0 OK, 0x2 CMD_INV, 0x3 ADDR_ALIGN, 0x4 BOUNDARY. Held until the next rejection.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, ERR.
- **IDLE:** req_ready=1. On req_valid, the request is evaluated and the FSM moves to ISSUE or ERR.
- **Checks, applied in priority order:**
  - CMD_INV: size bytes (1<<req_size) exceed NB. With DATA_WIDTH=32 this makes size 11 illegal.
  - ADDR_ALIGN: req_addr is not a multiple of the size bytes.
  - BOUNDARY: the burst crosses a 4 KB page. Applies only with the macro compiled in and req_inc=1. Crossing means last_addr[ADDR_WIDTH-1:12] ≠ req_addr[ADDR_WIDTH-1:12], where last_addr = req_addr + req_len*(1<<req_size).
- **ERR:** lasts exactly one cycle. err_valid=1 and err_status holds the failing code. No beat is emitted. Next state is IDLE.
- **ISSUE:** beat_valid=1.
  - beat_wstrb = ((1<<size bytes)-1) << beat_addr[log2(NB)-1:0]. The value is never 0.
  - On each beat_valid && beat_ready: beat_idx increments, and beat_addr advances by the size bytes if req_inc=1, otherwise stays fixed.
  - When the accepted beat has beat_idx == latched len, the FSM goes to IDLE.
- beat_last = (beat_idx == latched len).
- Address arithmetic is modulo 2^ADDR_WIDTH.
- In fixed-address mode beat_wstrb is the same on every beat.

## Timing
- Reset: every output except req_ready resets to 0; req_ready resets to 1. The FSM resets to IDLE.
- A reset asserted mid-burst abandons the remaining beats, with no error pulse.
- A request accepted at edge N gives first beat_valid, or err_valid, in cycle N+1. All outputs are registered.
- With beat_ready held high, a burst of L beats occupies L cycles.
- After the last beat handshake, req_ready=1 the following cycle. There is one idle cycle between bursts.
- While beat_valid=1 and beat_ready=0, beat_addr, beat_wstrb, beat_idx and beat_last hold stable.
- The request inputs are sampled only on the req handshake cycle and are ignored at all other times.
- req_len=0 gives a single beat with beat_last=1.
- req_len at its maximum value gives 2^LEN_WIDTH beats; beat_idx does not wrap before the last beat.

## Configuration
- Macro: AXI_BEAT_ALIGNER_BOUNDARY_CHECK_EN.
- Defined: incrementing bursts that cross a 4 KB page are rejected with status 0x4.
- Undefined: the boundary check is removed. Such bursts are issued and the address increments across the page; status 0x4 is never produced.

## Structure
- Shared package uart_axi_pkg holds:
  - status codes STATUS_OK, STATUS_CMD_INV, STATUS_ADDR_ALIGN, STATUS_BOUNDARY;
  - the size enum;
  - the FSM state typedef.
- Sub-module axi_strb_gen (combinational; inputs size and address low bits; output NB-bit strobe) is instantiated for beat_wstrb.

## Test plan
- **Incrementing 32-bit burst (DATA_WIDTH=32):** addr 0x1000, size 10, len 3, inc=1, beat_ready=1 → beats at 0x1000/0x1004/0x1008/0x100C, wstrb 0xF each, beat_last on beat 3, req_ready high in the following cycle.
- **Byte burst:** addr 0x2001, size 00, len 2, inc=1 → addresses 0x2001/0x2002/0x2003 with wstrb 0x2/0x4/0x8.
- **Error codes:**
  - size 01 at addr 0x3003 → err_valid pulse, status 0x3, no beat_valid.
  - size 11 with DATA_WIDTH=32 → status 0x2.
- **Boundary (macro defined):** addr 0x0FF8, size 10, len 3, inc=1 → status 0x4. With the macro undefined, 4 beats are issued at 0x0FF8 through 0x1004.
- **Backpressure and fixed mode:** fixed-mode burst addr 0x40, size 01, len 1, with beat_ready low for 3 cycles → outputs stable at 0x40 / wstrb 0x3. Then 2 beats are issued, both at 0x40.
- **Reset mid-burst:** assert rst during beat 1 of a len-7 burst → next cycle beat_valid=0, req_ready=1, err_valid=0.
